// File: rtl/frq_divider_rom_ctl.sv
// rtl/frq_divider_rom_ctl.sv - ROM-indexed glitch-free clock divider with run/stop control
// Optional select synchroniser: define FRQ_DIV_SEL_SYNC_EN.
module frq_divider_rom_ctl #(
    parameter int SEL_W = 5,
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [SEL_W-1:0] f_select,
    output logic             clk_out,
    output logic             tick,
    output logic             pending,
    output logic [CNT_W-1:0] ratio
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int               WIDE_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] R_MAX  = '1;

    logic [SEL_W-1:0] sel_s;

`ifdef FRQ_DIV_SEL_SYNC_EN
    logic [SEL_W-1:0] sel_meta_q, sel_meta_d;
    logic [SEL_W-1:0] sel_sync_q, sel_sync_d;

    always_comb begin
        sel_meta_d = f_select;
        sel_sync_d = sel_meta_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_meta_q <= '0;
            sel_sync_q <= '0;
        end else begin
            sel_meta_q <= sel_meta_d;
            sel_sync_q <= sel_sync_d;
        end
    end

    assign sel_s = sel_sync_q;
`else
    assign sel_s = f_select;
`endif

    // Ratio ROM: (2 | k[0]) << (k >> 1), computed two bits wider so saturation is detectable.
    logic [SEL_W-2:0]  rom_shift;
    logic [WIDE_W-1:0] rom_wide;
    logic [CNT_W-1:0]  rom_ratio;
    logic [CNT_W-1:0]  rom_high;
    logic [CNT_W-1:0]  rom_low;

    always_comb begin
        rom_shift = sel_s[SEL_W-1:1];
        rom_wide  = '0;
        rom_ratio = R_MAX;
        if (int'(rom_shift) <= CNT_W) begin
            rom_wide = (WIDE_W'(2) | WIDE_W'(sel_s[0])) << rom_shift;
            if (rom_wide <= WIDE_W'(R_MAX)) begin
                rom_ratio = rom_wide[CNT_W-1:0];
            end
        end
        rom_high = rom_ratio >> 1;
        rom_low  = rom_ratio - rom_high;
    end

    state_t           state_q, state_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_act_q, sel_act_d;
    logic             load;

    always_comb begin
        state_d   = state_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        ratio_d   = ratio_q;
        low_d     = low_q;
        cnt_d     = cnt_q;
        sel_act_d = sel_act_q;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    load = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d   = LOW;
                    clk_out_d = 1'b0;
                    cnt_d     = low_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    // Period boundary: the only place a new ratio or a stop takes effect.
                    if (en) begin
                        load = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        ratio_d   = '0;
                        low_d     = '0;
                        sel_act_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d   = HIGH;
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
            ratio_d   = rom_ratio;
            low_d     = rom_low;
            cnt_d     = rom_high - CNT_W'(1);
            sel_act_d = sel_s;
        end

        pending_d = (state_d != IDLE) && (sel_s != sel_act_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            pending_q <= 1'b0;
            ratio_q   <= '0;
            low_q     <= '0;
            cnt_q     <= '0;
            sel_act_q <= '0;
        end else begin
            state_q   <= state_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
            ratio_q   <= ratio_d;
            low_q     <= low_d;
            cnt_q     <= cnt_d;
            sel_act_q <= sel_act_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign pending = pending_q;
    assign ratio   = ratio_q;

endmodule

// File: doc/frq_divider_rom_ctl.md
Name: frq_divider_rom_ctl

Overview:
- Parametrised ROM-controlled clock divider, successor to the 5-bit-select single-mode divider.
- The select code indexes an internal ratio ROM that gives a high-phase count and a low-phase count.
- Ratio changes are applied glitch-free, only at output-period boundaries.
- Adds run enable, clean stop, period tick, pending-change flag and current-ratio readback; sits between the top-level pin wrapper and downstream clocked logic.

Parameters:
- SEL_W, 5, width of the select code; the ROM has 2^SEL_W entries.
- CNT_W, 18, width of the ratio and phase counters.

Ports:
- clk  input  1  divider source clock
- reset_n  input  1  asynchronous active-low reset
- en  input  1  run enable; level-sensitive
- f_select  input  SEL_W  requested ROM index
- clk_out  output  1  divided clock, registered
- tick  output  1  one-cycle pulse on the first high cycle of each output period
- pending  output  1  requested select differs from the active select while running
- ratio  output  CNT_W  active divide ratio; 0 when idle

Behaviour:
- ROM entry k: R(k) = (2 + (k & 1)) << (k >> 1).
  - Examples: k=0..7 gives 2, 3, 4, 6, 8, 12, 16, 24.
  - If R(k) exceeds 2^CNT_W-1, it saturates to 2^CNT_W-1.
- Phase split: H = floor(R/2), L = R - H. Minimum H=1, L=1.
- The ROM is combinational on the sampled select; its output is captured into active registers (ratio, H, L) only at load points.
- States: IDLE, HIGH, LOW.
- Reset (async, any time, including mid-period): state=IDLE, clk_out=0, tick=0, pending=0, ratio=0, counters=0. No partial period completes after reset.
- IDLE, edge with en=1: load R/H/L from f_select; state=HIGH; clk_out<=1; tick<=1; cnt<=H-1.
- IDLE, en=0: hold all outputs at reset values.
- HIGH:
  - cnt==0: state=LOW, clk_out<=0, cnt<=L-1.
  - Otherwise: cnt--.
  - tick<=0.
- LOW, cnt==0 (period boundary):
  - en=1: reload R/H/L from the current select; state=HIGH; clk_out<=1; tick<=1; cnt<=H_new-1.
  - en=0: state=IDLE, ratio<=0.
- LOW, otherwise: cnt--.
- Resulting waveform: clk_out is high for exactly H clk cycles and low for exactly L cycles per period. The first rising clk_out is one clk edge after en is sampled high.
- Select changes mid-period: the current period finishes with the old ratio, and the new ratio takes effect from the next rising clk_out. Intermediate select values seen between boundaries are ignored.
- pending = (state != IDLE) && (sampled select != active select). It is registered, so it updates one cycle after the select changes and clears on the boundary cycle that loads the new value.
- en deasserted mid-period gives a clean stop: the current period completes and clk_out ends low. en re-asserted before the boundary has no visible effect.
- Simultaneous select change and en drop at a boundary: go to IDLE; the select is not loaded.
- Counters never wrap: the reload value is always at least 0 because H and L are at least 1.

Optional Feature:
- Macro: FRQ_DIV_SEL_SYNC_EN.
- Defined:
  - f_select passes through a two-flop synchroniser (reset to 0) before the ROM and the pending compare.
  - All select-to-effect latencies grow by 2 clk cycles.
  - en is not synchronised.
- Undefined: f_select is used directly and must be synchronous to clk.

Test Plan:
- sel=0, en=1 -> clk_out 1 high / 1 low repeating; tick every 2 cycles; ratio=2.
- sel=1 -> clk_out 1 high / 2 low; ratio=3; tick period 3.
- Running sel=2 (R=4), switch to sel=4 in the 2nd high cycle -> pending=1 next cycle; current period completes 2H/2L; next period 4H/4L; pending=0 at the load.
- sel=5 (R=12), drop en after 3 high cycles -> remaining 3 high and 6 low complete; then IDLE, clk_out=0, ratio=0, no further tick.
- Assert reset_n=0 mid-HIGH at sel=3 -> clk_out, tick, pending, ratio go 0 immediately without waiting for a clk edge; after release with en=1, the first rising clk_out comes one edge later.
- CNT_W=8, sel=31 -> ratio saturates to 255, H=127, L=128. With FRQ_DIV_SEL_SYNC_EN defined, the select-change response in the switch test is delayed by 2 cycles.
